// File: rtl/multififo_pkg.sv
// rtl/multififo_pkg.sv - shared widths and helpers for the multi-port FIFO
package multififo_pkg;

  localparam int CNT_W  = 16;
  localparam int CNT_IW = 17;

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Single conditional subtract is enough because k never exceeds depth.
  function automatic logic [CNT_IW-1:0] ptr_add(input logic [CNT_IW-1:0] ptr,
                                                input logic [CNT_IW-1:0] k,
                                                input logic [CNT_IW-1:0] depth);
    logic [CNT_IW-1:0] sum;
    sum = ptr + k;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

  function automatic logic [CNT_IW-1:0] umin(input logic [CNT_IW-1:0] a,
                                             input logic [CNT_IW-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/multififo_rdmux.sv
// rtl/multififo_rdmux.sv - one read lane: selects the LANE-th oldest entry
module multififo_rdmux
  import multififo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PW    = 3,
  parameter int RW    = 1,
  parameter int LANE  = 0
) (
  input  logic [WIDTH-1:0] store [DEPTH],
  input  logic [PW-1:0]    rptr,
  input  logic [RW-1:0]    rgiven,
  output logic [WIDTH-1:0] dout_lane,
  output logic             dvalid
);

  logic [PW-1:0] idx;

  // Lane is valid only when granted; ungranted lanes read as zero.
  always_comb begin
    idx       = PW'(ptr_add(CNT_IW'(rptr), CNT_IW'(LANE), CNT_IW'(DEPTH)));
    dvalid    = CNT_IW'(LANE) < CNT_IW'(rgiven);
    dout_lane = dvalid ? store[idx] : '0;
  end

endmodule

// File: rtl/multififo_wn_rm.sv
// rtl/multififo_wn_rm.sv - NWR-write / NRD-read circular FIFO with sticky errors
module multififo_wn_rm
  import multififo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int NWR     = 8,
  parameter int NRD     = 1,
  parameter int PARTIAL = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       softreset,
  input  logic [$clog2(NWR+1)-1:0]   writes,
  input  logic [WIDTH*NWR-1:0]       din,
  input  logic [$clog2(NRD+1)-1:0]   reads,
  output logic [$clog2(NWR+1)-1:0]   wtaken,
  output logic [$clog2(NRD+1)-1:0]   rgiven,
  output logic [WIDTH*NRD-1:0]       dout,
  output logic [NRD-1:0]             dvalid,
  output logic [15:0]                count,
  output logic [15:0]                frees,
  output logic                       err_wr,
  output logic                       err_rd
);

  localparam int PW = ptr_width(DEPTH);
  localparam int WW = $clog2(NWR+1);
  localparam int RW = $clog2(NRD+1);
  localparam logic [CNT_IW-1:0] DEPTH_C = CNT_IW'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CNT_IW-1:0] cnt, wreq, rreq, wt, rg;
  logic [CNT_W-1:0]  free_n;
  logic              badw, badr;

  assign wreq   = CNT_IW'(writes);
  assign rreq   = CNT_IW'(reads);
  assign badw   = wreq > CNT_IW'(NWR);
  assign badr   = rreq > CNT_IW'(NRD);
  assign free_n = CNT_W'(DEPTH_C - cnt);

  assign wtaken = WW'(wt);
  assign rgiven = RW'(rg);
  assign count  = cnt[CNT_W-1:0];
  assign frees  = free_n;

  // Grants use start-of-cycle occupancy only, so reads never free space for same-cycle writes.
  always_comb begin
    wt = '0;
    rg = '0;
    if (!rst && !softreset) begin
      if (!badw) begin
        if (PARTIAL != 0) wt = umin(wreq, CNT_IW'(free_n));
        else              wt = (wreq + cnt <= DEPTH_C) ? wreq : '0;
      end
      if (!badr) begin
        if (PARTIAL != 0) rg = umin(rreq, cnt);
        else              rg = (rreq <= cnt) ? rreq : '0;
      end
    end
  end

  // Accepted write lanes land at consecutive wrapped slots starting at wptr.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NWR; k++) begin
      if (CNT_IW'(k) < wt)
        mem[PW'(ptr_add(CNT_IW'(wptr), CNT_IW'(k), DEPTH_C))] <= din[k*WIDTH +: WIDTH];
    end
  end

  // Pointers, occupancy and sticky error flags; softreset overrides all traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      err_wr <= 1'b0;
      err_rd <= 1'b0;
    end else if (softreset) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      err_wr <= 1'b0;
      err_rd <= 1'b0;
    end else begin
      wptr <= PW'(ptr_add(CNT_IW'(wptr), wt, DEPTH_C));
      rptr <= PW'(ptr_add(CNT_IW'(rptr), rg, DEPTH_C));
      cnt  <= cnt + wt - rg;
      if (badw || wreq > wt) err_wr <= 1'b1;
      if (badr || rreq > rg) err_rd <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    multififo_rdmux #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .PW   (PW),
      .RW   (RW),
      .LANE (k)
    ) u_rdmux (
      .store    (mem),
      .rptr     (rptr),
      .rgiven   (rgiven),
      .dout_lane(dout[k*WIDTH +: WIDTH]),
      .dvalid   (dvalid[k])
    );
  end

endmodule

// File: tb/tb_multififo_wn_rm.sv
// tb/tb_multififo_wn_rm.sv - self-checking bench: instance 0 all-or-nothing, instance 1 partial
module tb_multififo_wn_rm;

  localparam int NWR   = 4;
  localparam int NRD   = 2;
  localparam int DEPTH = 6;

  logic        clk;
  logic        rst;
  logic [2:0]  writes    [2];
  logic [31:0] din       [2];
  logic [1:0]  reads     [2];
  logic        softreset [2];
  logic [2:0]  wtaken    [2];
  logic [1:0]  rgiven    [2];
  logic [15:0] dout      [2];
  logic [1:0]  dvalid    [2];
  logic [15:0] count     [2];
  logic [15:0] frees     [2];
  logic        err_wr    [2];
  logic        err_rd    [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] mq [2][$];
  bit         mew [2];
  bit         mer [2];

  multififo_wn_rm #(.WIDTH(8), .DEPTH(DEPTH), .NWR(NWR), .NRD(NRD), .PARTIAL(0)) dut0 (
    .clk(clk), .rst(rst), .softreset(softreset[0]), .writes(writes[0]), .din(din[0]),
    .reads(reads[0]), .wtaken(wtaken[0]), .rgiven(rgiven[0]), .dout(dout[0]),
    .dvalid(dvalid[0]), .count(count[0]), .frees(frees[0]), .err_wr(err_wr[0]),
    .err_rd(err_rd[0])
  );

  multififo_wn_rm #(.WIDTH(8), .DEPTH(DEPTH), .NWR(NWR), .NRD(NRD), .PARTIAL(1)) dut1 (
    .clk(clk), .rst(rst), .softreset(softreset[1]), .writes(writes[1]), .din(din[1]),
    .reads(reads[1]), .wtaken(wtaken[1]), .rgiven(rgiven[1]), .dout(dout[1]),
    .dvalid(dvalid[1]), .count(count[1]), .frees(frees[1]), .err_wr(err_wr[1]),
    .err_rd(err_rd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Grants from the acceptance rules; instance 1 is the partial-acceptance one.
  function automatic void grant(input int i, input int w, input int r, input bit sr,
                                output int ewt, output int erg);
    int c;
    c   = mq[i].size();
    ewt = 0;
    erg = 0;
    if (rst || sr) return;
    if (w <= NWR) begin
      if (i == 1) ewt = (w < DEPTH - c) ? w : DEPTH - c;
      else        ewt = (w + c <= DEPTH) ? w : 0;
    end
    if (r <= NRD) begin
      if (i == 1) erg = (r < c) ? r : c;
      else        erg = (r <= c) ? r : 0;
    end
  endfunction

  initial begin : rst_model
    forever begin
      @(posedge rst);
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        mew[i] = 1'b0;
        mer[i] = 1'b0;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int ewt, erg;
        logic [15:0] edout;
        logic [1:0]  edv;
        grant(i, int'(writes[i]), int'(reads[i]), softreset[i], ewt, erg);
        edout = '0;
        edv   = '0;
        for (int k = 0; k < NRD; k++) begin
          if (k < erg) begin
            edout[k*8 +: 8] = mq[i][k];
            edv[k]          = 1'b1;
          end
        end
        chk($sformatf("u%0d.wtaken", i), 32'(wtaken[i]), 32'(ewt));
        chk($sformatf("u%0d.rgiven", i), 32'(rgiven[i]), 32'(erg));
        chk($sformatf("u%0d.dout", i),   32'(dout[i]),   32'(edout));
        chk($sformatf("u%0d.dvalid", i), 32'(dvalid[i]), 32'(edv));
        chk($sformatf("u%0d.count", i),  32'(count[i]),  mq[i].size());
        chk($sformatf("u%0d.frees", i),  32'(frees[i]),  DEPTH - mq[i].size());
        chk($sformatf("u%0d.err_wr", i), 32'(err_wr[i]), 32'(mew[i]));
        chk($sformatf("u%0d.err_rd", i), 32'(err_rd[i]), 32'(mer[i]));
        if (!rst) begin
          if (softreset[i]) begin
            mq[i].delete();
            mew[i] = 1'b0;
            mer[i] = 1'b0;
          end else begin
            for (int k = 0; k < erg; k++) void'(mq[i].pop_front());
            for (int k = 0; k < ewt; k++) mq[i].push_back(din[i][k*8 +: 8]);
            if (int'(writes[i]) > ewt) mew[i] = 1'b1;
            if (int'(reads[i]) > erg)  mer[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic apply(input int i, input int w, input logic [31:0] d, input int r, input bit sr);
    writes[i]    = 3'(w);
    din[i]       = d;
    reads[i]     = 2'(r);
    softreset[i] = sr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      writes[i]    = '0;
      din[i]       = '0;
      reads[i]     = '0;
      softreset[i] = 1'b0;
    end
  endtask

  initial begin : stim
    for (int i = 0; i < 2; i++) begin
      writes[i]    = '0;
      din[i]       = '0;
      reads[i]     = '0;
      softreset[i] = 1'b0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", 32'(count[0]), 0);
    chk("rst_frees", 32'(frees[0]), 6);
    chk("rst_err_wr", 32'(err_wr[0]), 0);
    chk("rst_err_rd", 32'(err_rd[0]), 0);

    // wrap across a non-power-of-two depth
    apply(0, 4, 32'hA3A2A1A0, 0, 0); chk("wrap_wt_a", 32'(wtaken[0]), 4); tick();
    chk("wrap_cnt_4a", 32'(count[0]), 4);
    apply(0, 0, 0, 2, 0); chk("wrap_dout_a10", 32'(dout[0]), 32'hA1A0); tick();
    chk("wrap_cnt_2a", 32'(count[0]), 2);
    apply(0, 0, 0, 2, 0); chk("wrap_dout_a32", 32'(dout[0]), 32'hA3A2); tick();
    chk("wrap_cnt_0a", 32'(count[0]), 0);
    apply(0, 4, 32'hB3B2B1B0, 0, 0); chk("wrap_wt_b", 32'(wtaken[0]), 4); tick();
    chk("wrap_cnt_4b", 32'(count[0]), 4);
    apply(0, 0, 0, 2, 0); chk("wrap_dout_b10", 32'(dout[0]), 32'hB1B0); tick();
    chk("wrap_cnt_2b", 32'(count[0]), 2);
    apply(0, 0, 0, 2, 0); chk("wrap_dout_b32", 32'(dout[0]), 32'hB3B2); tick();
    chk("wrap_cnt_0b", 32'(count[0]), 0);
    apply(0, 0, 0, 2, 0);
    chk("empty_rgiven", 32'(rgiven[0]), 0);
    chk("empty_dvalid", 32'(dvalid[0]), 0);
    chk("empty_dout", 32'(dout[0]), 0);
    tick();
    chk("empty_err_rd", 32'(err_rd[0]), 1);

    // all-or-nothing refusal with a concurrent read
    apply(0, 0, 0, 0, 1); tick();
    chk("sr_clear_err_rd", 32'(err_rd[0]), 0);
    apply(0, 4, 32'hC3C2C1C0, 0, 0); tick();
    apply(0, 3, 32'h00EEEEEE, 2, 0);
    chk("refuse_wt", 32'(wtaken[0]), 0);
    chk("refuse_rg", 32'(rgiven[0]), 2);
    chk("refuse_dout", 32'(dout[0]), 32'hC1C0);
    tick();
    chk("refuse_cnt", 32'(count[0]), 2);
    chk("refuse_err_wr", 32'(err_wr[0]), 1);

    // full with simultaneous read and write: no bypass
    apply(0, 4, 32'hD3D2D1D0, 0, 0); chk("fill_wt", 32'(wtaken[0]), 4); tick();
    chk("full_cnt", 32'(count[0]), 6);
    chk("full_frees", 32'(frees[0]), 0);
    apply(0, 2, 32'h0000EEEE, 2, 0);
    chk("full_rw_wt", 32'(wtaken[0]), 0);
    chk("full_rw_rg", 32'(rgiven[0]), 2);
    chk("full_rw_dout", 32'(dout[0]), 32'hC3C2);
    tick();
    chk("full_rw_cnt", 32'(count[0]), 4);

    // softreset beats a same-cycle write
    apply(0, 2, 32'h00001111, 0, 1); chk("sr_wt", 32'(wtaken[0]), 0); tick();
    chk("sr_cnt", 32'(count[0]), 0);
    chk("sr_err_wr", 32'(err_wr[0]), 0);

    // illegal write request on a fresh partial instance
    apply(1, 5, 32'h55555555, 0, 0); chk("bad_wt", 32'(wtaken[1]), 0); tick();
    chk("bad_err_wr", 32'(err_wr[1]), 1);
    chk("bad_cnt", 32'(count[1]), 0);
    apply(1, 0, 0, 0, 1); tick();
    chk("bad_sr_err_wr", 32'(err_wr[1]), 0);

    // partial acceptance and partial read grant
    apply(1, 4, 32'hF3F2F1F0, 0, 0); tick();
    apply(1, 4, 32'hC3C2C1C0, 0, 0); chk("part_wt", 32'(wtaken[1]), 2); tick();
    chk("part_cnt", 32'(count[1]), 6);
    chk("part_frees", 32'(frees[1]), 0);
    chk("part_err_wr", 32'(err_wr[1]), 1);
    apply(1, 0, 0, 2, 0); chk("part_dout_f10", 32'(dout[1]), 32'hF1F0); tick();
    apply(1, 0, 0, 2, 0); chk("part_dout_f32", 32'(dout[1]), 32'hF3F2); tick();
    apply(1, 0, 0, 1, 0); chk("part_dout_c0", 32'(dout[1]), 32'h00C0); tick();
    chk("part_cnt1", 32'(count[1]), 1);
    apply(1, 0, 0, 2, 0);
    chk("part_rg", 32'(rgiven[1]), 1);
    chk("part_dvalid", 32'(dvalid[1]), 32'h1);
    chk("part_dout_c1", 32'(dout[1]), 32'h00C1);
    tick();
    chk("part_err_rd", 32'(err_rd[1]), 1);

    // asynchronous reset mid-traffic
    apply(0, 3, 32'h00E2E1E0, 0, 0); tick();
    chk("arst_pre_cnt", 32'(count[0]), 3);
    apply(0, 0, 0, 1, 0);
    chk("arst_pre_dout", 32'(dout[0]), 32'h00E0);
    #1 rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(count[0]), 0);
    chk("arst_frees", 32'(frees[0]), 6);
    chk("arst_dout", 32'(dout[0]), 0);
    chk("arst_rg", 32'(rgiven[0]), 0);
    rst = 1'b0;
    tick();
    apply(0, 0, 0, 1, 0); chk("arst_post_rg", 32'(rgiven[0]), 0); tick();

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
